// File: rtl/credit_send_adapter.sv
// Credit-based send adapter: one-entry upstream holding buffer, issues send_en only while holding a credit.
// Optional sticky protocol-error flag enabled by defining CREDIT_SEND_ADAPTER_ERR_CHECK_EN.
module credit_send_adapter #(
   parameter int unsigned data_width   = 32,
   parameter int unsigned num_credits  = 2,
   parameter int unsigned credit_width = $clog2(num_credits + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    recv_en,
   output logic                    recv_rdy,
   input  logic [data_width-1:0]   recv_msg,
   output logic                    send_en,
   output logic [data_width-1:0]   send_msg,
   input  logic                    credit_en,
   output logic [credit_width-1:0] credits,
   output logic                    err
);

   localparam logic [credit_width:0] max_cnt = (credit_width + 1)'(num_credits);

   logic                    buf_valid;
   logic [data_width-1:0]   buf_msg;
   logic [credit_width-1:0] cnt;
   logic [credit_width:0]   nxt;
   logic                    overflow;

   always_comb begin
      send_en  = buf_valid & (cnt != '0);
      send_msg = buf_msg;
      recv_rdy = ~buf_valid | send_en;
      credits  = cnt;
   end

   // One extra bit so a return at full count is visible as overflow rather than wrapping.
   always_comb begin
      nxt      = {1'b0, cnt} - {{credit_width{1'b0}}, send_en} + {{credit_width{1'b0}}, credit_en};
      overflow = nxt > max_cnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_valid <= 1'b0;
         buf_msg   <= '0;
      end else if (recv_en) begin
         buf_valid <= 1'b1;
         buf_msg   <= recv_msg;
      end else if (send_en) begin
         buf_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= max_cnt[credit_width-1:0];
      else if (overflow)
         cnt <= max_cnt[credit_width-1:0];
      else
         cnt <= nxt[credit_width-1:0];
   end

`ifdef CREDIT_SEND_ADAPTER_ERR_CHECK_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (reset)
         err_q <= 1'b0;
      else if (overflow || (recv_en && !recv_rdy))
         err_q <= 1'b1;
   end

   always_comb err = err_q;
`else
   always_comb err = 1'b0;
`endif

endmodule

// File: tb/tb_credit_send_adapter.sv
// Bench for credit_send_adapter: directed literal checks plus randomized traffic against a queue-based model.
module tb_credit_send_adapter;

   localparam int NC = 2;
   localparam int DW = 32;
   localparam int CW = $clog2(NC + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          recv_en;
   logic          recv_rdy;
   logic [DW-1:0] recv_msg;
   logic          send_en;
   logic [DW-1:0] send_msg;
   logic          credit_en;
   logic [CW-1:0] credits;
   logic          err;

   int checks = 0;
   int errors = 0;

   credit_send_adapter #(.data_width(DW), .num_credits(NC)) dut (
      .clk(clk), .reset(reset), .recv_en(recv_en), .recv_rdy(recv_rdy),
      .recv_msg(recv_msg), .send_en(send_en), .send_msg(send_msg),
      .credit_en(credit_en), .credits(credits), .err(err)
   );

   always #5 clk = ~clk;

`ifdef CREDIT_SEND_ADAPTER_ERR_CHECK_EN
   localparam bit ERR_BUILD = 1'b1;
`else
   localparam bit ERR_BUILD = 1'b0;
`endif

   // Behavioural model: the holding buffer is a queue of at most one message,
   // the credit counter a plain integer clamped to NC.
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] m_last;
   int            m_credits;
   bit            m_err;
   bit            started = 1'b0;

   function automatic bit m_send();
      return (m_q.size() > 0) && (m_credits > 0);
   endfunction

   function automatic bit m_rdy();
      return (m_q.size() == 0) || m_send();
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_q.delete();
         m_last    = '0;
         m_credits = NC;
         m_err     = 1'b0;
         started   = 1'b1;
      end else if (started) begin
         bit s;
         int c;
         s = m_send();
         if (recv_en && !m_rdy()) m_err = 1'b1;
         c = m_credits - int'(s) + int'(credit_en);
         if (c > NC) begin
            c     = NC;
            m_err = 1'b1;
         end
         m_credits = c;
         if (s) void'(m_q.pop_front());
         if (recv_en) begin
            m_q.delete();
            m_q.push_back(recv_msg);
            m_last = recv_msg;
         end
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started && !reset) begin
         chk("m_send_en",  DW'(send_en),  DW'(m_send()));
         chk("m_recv_rdy", DW'(recv_rdy), DW'(m_rdy()));
         chk("m_send_msg", send_msg,      m_last);
         chk("m_credits",  DW'(credits),  DW'(m_credits));
         chk("m_err",      DW'(err),      DW'(ERR_BUILD & m_err));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic outs(input string tag, input bit se, input logic [DW-1:0] sm,
                       input bit rr, input int cr);
      chk({tag, "_send_en"},  DW'(send_en),  DW'(se));
      if (se) chk({tag, "_send_msg"}, send_msg, sm);
      chk({tag, "_recv_rdy"}, DW'(recv_rdy), DW'(rr));
      chk({tag, "_credits"},  DW'(credits),  DW'(cr));
   endtask

   initial begin
      reset = 1'b1; recv_en = 1'b1; recv_msg = 32'hFF; credit_en = 1'b0;
      tick(); tick();
      reset = 1'b0; recv_en = 1'b0;
      tick();
      outs("reset", 1'b0, '0, 1'b1, 2);
      chk("reset_send_msg", send_msg, 32'h0);
      chk("reset_err", DW'(err), 32'h0);

      // Streaming with no credit return
      recv_en = 1'b1; recv_msg = 32'hA1; tick();
      recv_msg = 32'hA2;
      outs("st1", 1'b1, 32'hA1, 1'b1, 2);
      tick();
      recv_en = 1'b0;
      outs("st2", 1'b1, 32'hA2, 1'b1, 1);
      tick();
      outs("st3", 1'b0, '0, 1'b1, 0);
      recv_en = 1'b1; recv_msg = 32'hA3; tick();
      recv_en = 1'b0;
      outs("held", 1'b0, '0, 1'b0, 0);

      // Credit return releases the held message
      credit_en = 1'b1; tick();
      credit_en = 1'b0;
      outs("cret", 1'b1, 32'hA3, 1'b1, 1);
      tick();
      outs("cret2", 1'b0, '0, 1'b1, 0);

      // Simultaneous send and return at one credit
      credit_en = 1'b1; tick();
      credit_en = 1'b0;
      recv_en = 1'b1; recv_msg = 32'h10; tick();
      for (int i = 1; i <= 8; i++) begin
         credit_en = 1'b1;
         recv_en   = (i < 8);
         recv_msg  = 32'h10 + DW'(i);
         outs("simul", 1'b1, 32'h10 + DW'(i - 1), 1'b1, 1);
         tick();
      end
      credit_en = 1'b0; recv_en = 1'b0;
      outs("simul_end", 1'b0, '0, 1'b1, 1);

      // Overflow saturates at NC
      credit_en = 1'b1; tick();
      outs("ovf_pre", 1'b0, '0, 1'b1, 2);
      tick();
      credit_en = 1'b0;
      outs("ovf", 1'b0, '0, 1'b1, 2);
      chk("ovf_err", DW'(err), DW'(ERR_BUILD));
      tick();
      chk("ovf_err_sticky", DW'(err), DW'(ERR_BUILD));

      // Mid-operation reset drops a held message
      recv_en = 1'b1; recv_msg = 32'h01; tick();
      recv_msg = 32'h02; tick();
      recv_en = 1'b0; tick();
      recv_en = 1'b1; recv_msg = 32'h55; tick();
      recv_en = 1'b0;
      outs("mid_held", 1'b0, '0, 1'b0, 0);
      reset = 1'b1; tick();
      reset = 1'b0; tick();
      outs("mid_rst", 1'b0, '0, 1'b1, 2);
      chk("mid_rst_msg", send_msg, 32'h0);
      chk("mid_rst_err", DW'(err), 32'h0);

      // Randomized traffic; the compare process checks every cycle
      for (int n = 0; n < 4000; n++) begin
         reset     = ($urandom_range(0, 299) == 0);
         recv_msg  = $urandom();
         recv_en   = recv_rdy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 49) == 0);
         if (int'(credits) < NC)
            credit_en = ($urandom_range(0, 2) != 0);
         else
            credit_en = ($urandom_range(0, 39) == 0);
         tick();
      end
      reset = 1'b0; recv_en = 1'b0; credit_en = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/credit_send_adapter.md
Name: credit_send_adapter

Overview:
- Initiator-side adapter that drives the enq side of a register-based en/rdy queue over a credit link.
- Upstream: callee en/rdy interface with a one-entry holding buffer.
- Downstream: issues send_en only when it holds a credit. Each credit represents one free remote queue entry, returned one per cycle by the remote deq logic.
- Sits between a producer and a remote normal queue, where the remote rdy cannot be sampled combinationally (long wires, clock-crossing wrappers).

Parameters:
- data_width, 32, message width in bits.
- num_credits, 2, initial credit count; equals remote queue num_entries; must be >= 1.
- credit_width, $clog2(num_credits+1), width of credit counter and credits port.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- recv_en  input  1  upstream enqueue call; legal only when recv_rdy=1.
- recv_rdy  output  1  adapter can accept a message this cycle.
- recv_msg  input  data_width  upstream message, sampled when recv_en=1.
- send_en  output  1  downstream enqueue strobe; one message transferred per asserted cycle.
- send_msg  output  data_width  message to remote queue; valid when send_en=1.
- credit_en  input  1  remote returns one credit (one entry dequeued) this cycle.
- credits  output  credit_width  current credit count (registered).
- err  output  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- State: buf_valid (1b), buf_msg (data_width), cnt (credit_width), err_q (1b).
- Reset, clk edge with reset=1:
  - buf_valid=0, buf_msg=0, cnt=num_credits, err_q=0.
  - All other inputs ignored that cycle, including when asserted mid-transfer. A message in the buffer is dropped.
  - Outputs after reset: recv_rdy=1, send_en=0, send_msg=0, credits=num_credits, err=0.
- Combinational outputs:
  - send_en = buf_valid & (cnt != 0)
  - send_msg = buf_msg
  - recv_rdy = ~buf_valid | send_en (the buffer drains and refills in the same cycle)
- Buffer update:
  - recv_en=1: buf_msg<=recv_msg, buf_valid<=1.
  - else if send_en=1: buf_valid<=0, buf_msg holds.
- Credit update, at most one send and one return per cycle:
  - nxt = cnt - send_en + credit_en, computed at credit_width+1 bits.
  - send_en and credit_en in the same cycle: cnt unchanged.
  - Overflow (nxt > num_credits): cnt <= num_credits (saturate); error event.
- Latency: a message accepted at edge N appears on send_en/send_msg in cycle N+1 if cnt>0. Otherwise it waits until the cycle after the credit returns.
- Throughput: 1 msg/cycle sustained when credits are available.
- Zero credits: send_en=0, buffer holds, recv_rdy=0 while the buffer is full. A credit_en in that cycle makes cnt=1 next cycle, and send fires then.
- num_credits=1: alternates send / wait-for-credit. The minimum round trip sets the rate.
- recv_en while recv_rdy=0: protocol error. The buffer is still overwritten; the old message is lost.

Optional Feature:
- Macro: CREDIT_SEND_ADAPTER_ERR_CHECK_EN.
- Defined:
  - err_q is set (sticky until reset) on credit overflow or on recv_en while recv_rdy=0.
  - err = err_q.
- Undefined:
  - err tied to 0; no err_q flop.
  - Overflow still saturates cnt; illegal recv_en still overwrites the buffer.
- Saturation and overwrite behaviour is identical in both builds.

Test Plan:
- Reset: apply reset for 2 cycles with recv_en=1 -> recv_rdy=1, send_en=0, credits=2, err=0 after release.
- Streaming: recv msgs 0xA1,0xA2 on back-to-back cycles, credit_en tied 0 -> send_en in the next two cycles with send_msg 0xA1 then 0xA2; credits 2->1->0; then recv 0xA3 -> held, recv_rdy=0, send_en=0.
- Credit return: with 0xA3 held at credits=0, pulse credit_en one cycle -> credits=1 next cycle, send_en=1 with 0xA3, then credits=0, recv_rdy=1.
- Simultaneous send and return: credits=1, buffer full, credit_en=1 on the send cycle -> credits stays 1, sustained 1 msg/cycle over 8 msgs 0x10..0x17 with credit_en held 1.
- Overflow: credits=2, pulse credit_en, send_en=0 -> credits stays 2. err=1 and stays 1 with the macro defined; err=0 without it.
- Mid-operation reset: buffer holds 0x55 at credits=0, assert reset -> buffer dropped; after release send_en=0, credits=2, recv_rdy=1.
